control_merge_rr_dataless: RTL and testbench

CONTROL_MERGE_RR_DATALESS -- requirements
Module: control_merge_rr_dataless

---
 rtl/dataless_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/control_merge_rr_dataless.sv | 124 ++++++++++++
 tb/tb_control_merge_rr_dataless.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dataless_ctrl_pkg.sv
// Shared types and helpers for the dataless control-merge block.
package dataless_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic-priority arbiter: first request at or after ptr wins.
module rr_arbiter #(
  parameter int SIZE = 2,
  parameter int IW   = 1
) (
  input  logic [SIZE-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [SIZE-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < SIZE; i++) begin
      j = int'(ptr) + i;
      if (j >= SIZE) j = j - SIZE;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/control_merge_rr_dataless.sv
// Dataless control merge with an eager fork to output and index channels.
// Define CMERGE_ROUND_ROBIN_EN for a rotating priority pointer; otherwise fixed priority.
module control_merge_rr_dataless
  import dataless_ctrl_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int INDEX_TYPE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       ins_valid,
  output logic [SIZE-1:0]       ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [INDEX_TYPE-1:0] index,
  output logic                  index_valid,
  input  logic                  index_ready
);

  state_t                  state_q, state_d;
  logic                    sent_o_q, sent_o_d;
  logic                    sent_i_q, sent_i_d;
  logic [INDEX_TYPE-1:0]   held_q, held_d;
  logic [INDEX_TYPE-1:0]   ptr;
  logic [INDEX_TYPE-1:0]   winner;
  logic [INDEX_TYPE-1:0]   arb_idx;
  logic [SIZE-1:0]         arb_grant;
  logic                    arb_any;
  logic                    have;
  logic                    o_done;
  logic                    i_done;
  logic                    complete;

  rr_arbiter #(
    .SIZE(SIZE),
    .IW  (INDEX_TYPE)
  ) u_arb (
    .req  (ins_valid),
    .ptr  (ptr),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

`ifdef CMERGE_ROUND_ROBIN_EN
  localparam int PTR_W = clog2(SIZE);

  logic [PTR_W-1:0] ptr_q;

  // The pointer only moves on a completed transfer, to just past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (complete) begin
      if (winner == INDEX_TYPE'(SIZE - 1)) ptr_q <= '0;
      else                                 ptr_q <= PTR_W'(winner + 1'b1);
    end
  end

  assign ptr = INDEX_TYPE'(ptr_q);
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sent_o_q <= 1'b0;
      sent_i_q <= 1'b0;
      held_q   <= '0;
    end else begin
      state_q  <= state_d;
      sent_o_q <= sent_o_d;
      sent_i_q <= sent_i_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sent_o_d    = sent_o_q;
    sent_i_d    = sent_i_q;
    held_d      = held_q;
    winner      = held_q;
    have        = 1'b1;
    outs_valid  = 1'b0;
    index_valid = 1'b0;
    index       = '0;
    ins_ready   = '0;
    o_done      = 1'b0;
    i_done      = 1'b0;
    complete    = 1'b0;

    // In HOLD the latched winner is kept even if other inputs become valid.
    if (state_q == IDLE) begin
      winner = arb_idx;
      have   = arb_any;
    end

    if (!rst && have) begin
      outs_valid  = ~sent_o_q;
      index_valid = ~sent_i_q;
      index       = winner;
      o_done      = sent_o_q | (outs_valid & outs_ready);
      i_done      = sent_i_q | (index_valid & index_ready);
      complete    = o_done & i_done;

      if (complete) begin
        for (int i = 0; i < SIZE; i++) begin
          if (INDEX_TYPE'(i) == winner) ins_ready[i] = 1'b1;
        end
        state_d  = IDLE;
        sent_o_d = 1'b0;
        sent_i_d = 1'b0;
      end else begin
        state_d  = HOLD;
        held_d   = winner;
        sent_o_d = o_done;
        sent_i_d = i_done;
      end
    end
  end

endmodule

// File: tb/tb_control_merge_rr_dataless.sv
// Directed self-checking bench for control_merge_rr_dataless (SIZE=4, INDEX_TYPE=2).
module tb_control_merge_rr_dataless;

  logic       clk;
  logic       rst;
  logic [3:0] ins_valid;
  logic [3:0] ins_ready;
  logic       outs_valid;
  logic       outs_ready;
  logic [1:0] index;
  logic       index_valid;
  logic       index_ready;

  int compared;
  int mismatched;

  control_merge_rr_dataless #(
    .SIZE      (4),
    .INDEX_TYPE(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .index      (index),
    .index_valid(index_valid),
    .index_ready(index_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic o_rdy, input logic i_rdy);
    @(posedge clk);
    #1;
    rst         = r;
    ins_valid   = v;
    outs_ready  = o_rdy;
    index_ready = i_rdy;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ov, input logic iv,
                          input logic [1:0] idx, input logic [3:0] rdy);
    checkOutput({tag, ".outs_valid"}, 32'(outs_valid), 32'(ov));
    checkOutput({tag, ".index_valid"}, 32'(index_valid), 32'(iv));
    if (iv) checkOutput({tag, ".index"}, 32'(index), 32'(idx));
    checkOutput({tag, ".ins_ready"}, 32'(ins_ready), 32'(rdy));
  endtask

  logic [1:0] exp_idx [5];

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    ins_valid   = '0;
    outs_ready  = 1'b0;
    index_ready = 1'b0;

    // Reset with traffic present: everything held at zero.
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    checkAll("reset0", 1'b0, 1'b0, 2'd0, 4'b0000);
    checkOutput("reset0.index_zero", 32'(index), 32'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    checkAll("reset1", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Single valid input, zero-latency completion.
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1);
    checkAll("single2", 1'b1, 1'b1, 2'd2, 4'b0100);

    // Pointer now past input 2: input 3 beats input 0 under round robin.
    applyStimulus(1'b0, 4'b1001, 1'b1, 1'b1);
`ifdef CMERGE_ROUND_ROBIN_EN
    checkAll("ptr3", 1'b1, 1'b1, 2'd3, 4'b1000);
`else
    checkAll("ptr3", 1'b1, 1'b1, 2'd0, 4'b0001);
`endif

    // All inputs valid for five cycles.
`ifdef CMERGE_ROUND_ROBIN_EN
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_idx = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
      checkAll($sformatf("all%0d", k), 1'b1, 1'b1, exp_idx[k],
               4'b0001 << exp_idx[k]);
    end

    // No valid input.
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    checkAll("none", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Output handshakes first, index channel stalls three cycles.
    applyStimulus(1'b0, 4'b0010, 1'b1, 1'b0);
    checkAll("fork0", 1'b1, 1'b1, 2'd1, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 1'b1, 1'b0);
    checkAll("fork1", 1'b0, 1'b1, 2'd1, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 1'b1, 1'b0);
    checkAll("fork2", 1'b0, 1'b1, 2'd1, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 1'b1, 1'b1);
    checkAll("fork3", 1'b0, 1'b1, 2'd1, 4'b0010);

    // Grant stays locked on input 1 while input 0 joins.
    applyStimulus(1'b0, 4'b0010, 1'b1, 1'b0);
    checkAll("lock0", 1'b1, 1'b1, 2'd1, 4'b0000);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0);
    checkAll("lock1", 1'b0, 1'b1, 2'd1, 4'b0000);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b1);
    checkAll("lock2", 1'b0, 1'b1, 2'd1, 4'b0010);
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b1);
    checkAll("lock3", 1'b1, 1'b1, 2'd0, 4'b0001);

    // Enter HOLD with no readies, stay there, then abandon it via reset.
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    checkAll("hold0", 1'b1, 1'b1, 2'd2, 4'b0000);
    applyStimulus(1'b0, 4'b1001, 1'b0, 1'b0);
    checkAll("hold1", 1'b1, 1'b1, 2'd2, 4'b0000);
    applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1);
    checkAll("hold_rst", 1'b0, 1'b0, 2'd0, 4'b0000);
    checkOutput("hold_rst.index_zero", 32'(index), 32'd0);
    applyStimulus(1'b0, 4'b1001, 1'b1, 1'b1);
    checkAll("after_rst", 1'b1, 1'b1, 2'd0, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
